// File: rtl/conv_param_store.sv
// Parameter store for the conv engine: 8-bit weights and BIAS_W-bit biases.
// A byte-stream loader (valid/ready) fills one region per load; biases are
// assembled little-endian from NB consecutive bytes. Two independent read
// ports return data one cycle after the request (read-first on collision).
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   load_start_i/sel_i/len_i      load request (region select, byte count)
//   byte_data_i/valid_i, byte_ready_o   byte stream handshake
//   load_busy_o, load_done_o, load_err_o  load status (err is sticky)
//   w_rd_en_i/addr_i -> w_rd_data_o/valid_o   weight read port
//   b_rd_en_i/addr_i -> b_rd_data_o/valid_o   bias read port
module conv_param_store #(
  parameter int unsigned W_DEPTH = 8192,
  parameter int unsigned B_DEPTH = 64,
  parameter int unsigned BIAS_W  = 32,
  parameter int unsigned LEN_W   = 16,
  localparam int unsigned W_AW   = $clog2(W_DEPTH),
  localparam int unsigned B_AW   = $clog2(B_DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_start_i,
  input  logic              load_sel_i,
  input  logic [LEN_W-1:0]  load_len_i,
  input  logic [7:0]        byte_data_i,
  input  logic              byte_valid_i,
  output logic              byte_ready_o,
  output logic              load_busy_o,
  output logic              load_done_o,
  output logic              load_err_o,
  input  logic              w_rd_en_i,
  input  logic [W_AW-1:0]   w_rd_addr_i,
  output logic [7:0]        w_rd_data_o,
  output logic              w_rd_valid_o,
  input  logic              b_rd_en_i,
  input  logic [B_AW-1:0]   b_rd_addr_i,
  output logic [BIAS_W-1:0] b_rd_data_o,
  output logic              b_rd_valid_o
);

  localparam int unsigned NB     = BIAS_W / 8;
  localparam int unsigned LANE_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [LANE_W-1:0] LastLane = LANE_W'(NB - 1);
  localparam logic [31:0] WMaxLen = 32'(W_DEPTH);
  localparam logic [31:0] BMaxLen = 32'(B_DEPTH * NB);

  typedef enum logic [1:0] {StIdle, StLoadW, StLoadB, StDone} state_e;

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [W_AW-1:0]     w_addr_q, w_addr_d;
  logic [B_AW-1:0]     b_addr_q, b_addr_d;
  logic [LANE_W-1:0]   lane_q, lane_d;
  logic [BIAS_W-1:0]   asm_q, asm_d;
  logic                err_q, err_d;

  logic                xfer, last_byte, w_we, b_we;
  logic [LANE_W+2:0]   lane_off;

  logic [7:0]          w_mem [W_DEPTH];
  logic [BIAS_W-1:0]   b_mem [B_DEPTH];

  logic [7:0]          w_rd_data_q;
  logic                w_rd_valid_q;
  logic [BIAS_W-1:0]   b_rd_data_q;
  logic                b_rd_valid_q;

  assign byte_ready_o = (state_q == StLoadW) || (state_q == StLoadB);
  assign load_busy_o  = (state_q != StIdle);
  assign load_done_o  = (state_q == StDone);
  assign load_err_o   = err_q;

  assign xfer      = byte_valid_i && byte_ready_o;
  assign last_byte = (cnt_q + LEN_W'(1)) == len_q;
  assign lane_off  = {lane_q, 3'b000};

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    w_addr_d = w_addr_q;
    b_addr_d = b_addr_q;
    lane_d   = lane_q;
    asm_d    = asm_q;
    err_d    = err_q;
    w_we     = 1'b0;
    b_we     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (load_start_i) begin
          if (load_len_i == '0) begin
            state_d = StDone;
          end else if ((!load_sel_i && (32'(load_len_i) > WMaxLen)) ||
                       ( load_sel_i && (32'(load_len_i) > BMaxLen))) begin
            err_d = 1'b1;
          end else begin
            err_d    = 1'b0;
            len_d    = load_len_i;
            cnt_d    = '0;
            w_addr_d = '0;
            b_addr_d = '0;
            lane_d   = '0;
            state_d  = load_sel_i ? StLoadB : StLoadW;
          end
        end
      end
      StLoadW, StLoadB: begin
        if (load_start_i) err_d = 1'b1;
        if (xfer) begin
          cnt_d = cnt_q + LEN_W'(1);
          if (state_q == StLoadW) begin
            w_we     = 1'b1;
            w_addr_d = w_addr_q + W_AW'(1);
          end else begin
            asm_d[lane_off +: 8] = byte_data_i;
            if (lane_q == LastLane) begin
              // Word complete: asm_d already carries the top byte.
              b_we     = 1'b1;
              lane_d   = '0;
              b_addr_d = b_addr_q + B_AW'(1);
            end else begin
              lane_d = lane_q + LANE_W'(1);
            end
          end
          if (last_byte) begin
            state_d = StDone;
            // A trailing partial word is dropped and flagged.
            if ((state_q == StLoadB) && (lane_q != LastLane)) err_d = 1'b1;
          end
        end
      end
      StDone: begin
        if (load_start_i) err_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      len_q    <= '0;
      cnt_q    <= '0;
      w_addr_q <= '0;
      b_addr_q <= '0;
      lane_q   <= '0;
      asm_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      w_addr_q <= w_addr_d;
      b_addr_q <= b_addr_d;
      lane_q   <= lane_d;
      asm_q    <= asm_d;
      err_q    <= err_d;
    end
  end

  // Storage is never reset; writes are suppressed during reset so an aborted
  // load cannot land a byte on the reset edge.
  always_ff @(posedge clk_i) begin
    if (w_we && !rst_i) w_mem[w_addr_q] <= byte_data_i;
    if (b_we && !rst_i) b_mem[b_addr_q] <= asm_d;
  end

  // Registered reads; nonblocking semantics give read-first on collisions.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_rd_data_q  <= '0;
      w_rd_valid_q <= 1'b0;
      b_rd_data_q  <= '0;
      b_rd_valid_q <= 1'b0;
    end else begin
      w_rd_valid_q <= w_rd_en_i;
      b_rd_valid_q <= b_rd_en_i;
      if (w_rd_en_i) w_rd_data_q <= w_mem[w_rd_addr_i];
      if (b_rd_en_i) b_rd_data_q <= b_mem[b_rd_addr_i];
    end
  end

  assign w_rd_data_o  = w_rd_data_q;
  assign w_rd_valid_o = w_rd_valid_q;
  assign b_rd_data_o  = b_rd_data_q;
  assign b_rd_valid_o = b_rd_valid_q;

endmodule
